// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S slave receive path. Captures serial stereo audio from an
// external master and presents {left,right} frames on a valid/ready stream.
//
// Ports:
//   clk        system clock
//   arst       asynchronous active-high reset
//   i2s_sclk   bit clock from external master (asynchronous)
//   i2s_lrclk  word select, 0 = left, 1 = right (asynchronous)
//   i2s_sdata  serial data, sampled on rising sclk (asynchronous)
//   out_data   {left, right}, each DATA_BW bits
//   out_valid  out_data holds an unconsumed frame
//   out_ready  consumer accepts when out_valid && out_ready
//   overflow   sticky: a completed frame was dropped
//   frame_err  sticky: lrclk changed before a full word was received
//   err_clr    synchronous clear of overflow and frame_err
module i2s_receiver #(
  parameter int DATA_BW     = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   i2s_sclk,
  input  logic                   i2s_lrclk,
  input  logic                   i2s_sdata,
  output logic [2*DATA_BW-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic                   frame_err,
  input  logic                   err_clr
);

  // state | meaning
  // WAIT_SYNC | waiting for the first lrclk change, sdata ignored
  // RX        | receiving slot bits for channel ch_q
  localparam logic [0:0] ST_WAIT_SYNC = 1'b0;
  localparam logic [0:0] ST_RX        = 1'b1;

  localparam int              CNT_W    = $clog2(DATA_BW + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BW - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   lr_prev_q, lr_prev_d;
  logic                   lr_seen_q, lr_seen_d;
  logic [0:0]             state_q, state_d;
  logic                   ch_q, ch_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BW-1:0]     shreg_q, shreg_d;
  logic                   word_done_q, word_done_d;
  logic [DATA_BW-1:0]     left_q, left_d;
  logic [DATA_BW-1:0]     right_q, right_d;
  logic                   have_left_q, have_left_d;
  logic                   frame_rdy_q, frame_rdy_d;
  logic [2*DATA_BW-1:0]   out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;

  logic sclk_s, lr_s, sd_s;
  logic sclk_rise, lr_change;
  logic ferr_set, ovf_set;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign lr_s      = lr_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  // The first rise after reset only records lrclk, so releasing reset in the
  // middle of a slot never looks like a word-select edge.
  assign lr_change = sclk_rise & lr_seen_q & (lr_s != lr_prev_q);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i2s_sclk};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], i2s_sdata};
    sclk_prev_d = sclk_s;
    lr_prev_d   = lr_prev_q;
    lr_seen_d   = lr_seen_q;
    state_d     = state_q;
    ch_d        = ch_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    word_done_d = 1'b0;
    left_d      = left_q;
    right_d     = right_q;
    have_left_d = have_left_q;
    frame_rdy_d = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ferr_set    = 1'b0;
    ovf_set     = 1'b0;

    if (sclk_rise) begin
      lr_prev_d = lr_s;
      lr_seen_d = 1'b1;
    end

    // Bit capture. The bit sampled on an lrclk change belongs to the
    // previous slot and is dropped; the MSB arrives on the next rise.
    case (state_q)
      ST_WAIT_SYNC: begin
        if (lr_change) begin
          state_d   = ST_RX;
          ch_d      = lr_s;
          bit_cnt_d = '0;
        end
      end
      default: begin
        if (lr_change) begin
          if (bit_cnt_q < CNT_FULL) begin
            ferr_set = 1'b1;
            if (!ch_q) have_left_d = 1'b0;
          end
          ch_d      = lr_s;
          bit_cnt_d = '0;
        end else if (sclk_rise && (bit_cnt_q < CNT_FULL)) begin
          shreg_d     = {shreg_q[DATA_BW-2:0], sd_s};
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          word_done_d = (bit_cnt_q == CNT_LAST);
        end
      end
    endcase

    // Word latch, one cycle after the last bit shifts in. ch_q cannot move
    // meanwhile because sclk phases span several clk cycles.
    if (word_done_q) begin
      if (!ch_q) begin
        left_d      = shreg_q;
        have_left_d = 1'b1;
      end else begin
        right_d = shreg_q;
        if (have_left_q) begin
          frame_rdy_d = 1'b1;
          have_left_d = 1'b0;
        end
      end
    end

    // Output stream: a waiting frame is never overwritten.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (frame_rdy_q) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = {left_q, right_q};
        out_valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end

    overflow_d  = (overflow_q  & ~err_clr) | ovf_set;
    frame_err_d = (frame_err_q & ~err_clr) | ferr_set;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      lr_seen_q   <= 1'b0;
      state_q     <= ST_WAIT_SYNC;
      ch_q        <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      word_done_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      have_left_q <= 1'b0;
      frame_rdy_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      sd_sync_q   <= sd_sync_d;
      sclk_prev_q <= sclk_prev_d;
      lr_prev_q   <= lr_prev_d;
      lr_seen_q   <= lr_seen_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      word_done_q <= word_done_d;
      left_q      <= left_d;
      right_q     <= right_d;
      have_left_q <= have_left_d;
      frame_rdy_q <= frame_rdy_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives I2S slots (sclk = clk/16, 32-bit
// slots, 24-bit words) and checks the output stream against hand values.
module tb_i2s_receiver;

  localparam int DATA_BW     = 24;
  localparam int SYNC_STAGES = 2;
  localparam int EXP_LAT     = SYNC_STAGES + 2;

  logic                 clk;
  logic                 arst;
  logic                 i2s_sclk;
  logic                 i2s_lrclk;
  logic                 i2s_sdata;
  logic [2*DATA_BW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;
  logic                 frame_err;
  logic                 err_clr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mark_cyc = -1;
  int rise_cyc = -1;
  logic vprev = 1'b0;
  logic [2*DATA_BW-1:0] beats[$];

  i2s_receiver #(.DATA_BW(DATA_BW), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .arst      (arst),
    .i2s_sclk  (i2s_sclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdata (i2s_sdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Logs every transfer and the cycle of each out_valid rise.
  always @(negedge clk) begin
    if (out_valid && !vprev) rise_cyc = cyc;
    vprev = out_valid;
    if (out_valid && out_ready) beats.push_back(out_data);
  end

  // Slot bit index 0 is the trailing bit of the previous slot, 1..24 carry
  // the word MSB first, 25..31 are padding. Filler bits are 1 so that any
  // wrongly captured filler shows up in the data.
  task automatic send_bits(input logic lr, input logic [23:0] w,
                           input int first, input int last, input int mark);
    for (int i = first; i < last; i++) begin
      @(negedge clk);
      i2s_sclk  = 1'b0;
      i2s_lrclk = lr;
      i2s_sdata = (i >= 1 && i <= 24) ? w[24-i] : 1'b1;
      repeat (8) @(negedge clk);
      i2s_sclk = 1'b1;
      if (i == mark) mark_cyc = cyc + 1;
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_bits(1'b0, l, 0, 32, -1);
    send_bits(1'b1, r, 0, 32, -1);
    repeat (4) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 out_ready = v;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #2 err_clr = 1'b1;
    @(posedge clk);
    #2 err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (out_data !== 48'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    arst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_nominal();
    beats.delete();
    rise_cyc = -1;
    mark_cyc = -1;
    send_bits(1'b1, 24'h0, 25, 32, -1);
    send_bits(1'b0, 24'hA5A5A5, 0, 32, -1);
    send_bits(1'b1, 24'h123456, 0, 32, 24);
    repeat (4) @(negedge clk);
    n_cmp++; if (beats.size() != 1) begin n_bad++; $display("FAIL nominal_count got %0d want 1", beats.size()); end
    else begin
      n_cmp++; if (beats[0] !== 48'hA5A5A5_123456) begin n_bad++; $display("FAIL nominal_data got %h want a5a5a5123456", beats[0]); end
    end
    n_cmp++; if (rise_cyc - mark_cyc != EXP_LAT) begin n_bad++; $display("FAIL nominal_latency got %0d want %0d", rise_cyc - mark_cyc, EXP_LAT); end
  endtask

  task automatic test_backpressure();
    beats.delete();
    set_ready(1'b0);
    send_frame(24'd1, 24'd2);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid got %b want 1", out_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_ovf_early got %b want 0", overflow); end
    send_frame(24'd3, 24'd4);
    n_cmp++; if (out_data !== {24'd1, 24'd2}) begin n_bad++; $display("FAIL bp_hold got %h want %h", out_data, {24'd1, 24'd2}); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_overflow got %b want 1", overflow); end
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    n_cmp++; if (beats.size() != 1 || beats[0] !== {24'd1, 24'd2}) begin n_bad++; $display("FAIL bp_transfer got %0d beats want 1 of %h", beats.size(), {24'd1, 24'd2}); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_drop got %b want 0", out_valid); end
    pulse_clr();
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_clr got %b want 0", overflow); end
    set_ready(1'b1);
  endtask

  task automatic test_short_slot();
    beats.delete();
    send_bits(1'b0, 24'hFFFF00, 0, 17, -1);
    send_bits(1'b1, 24'h0F0F0F, 0, 32, -1);
    repeat (4) @(negedge clk);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL short_ferr got %b want 1", frame_err); end
    n_cmp++; if (beats.size() != 0) begin n_bad++; $display("FAIL short_noframe got %0d want 0", beats.size()); end
    pulse_clr();
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL short_clr got %b want 0", frame_err); end
    send_frame(24'h654321, 24'hFEDCBA);
    n_cmp++; if (beats.size() != 1 || beats[0] !== 48'h654321_FEDCBA) begin n_bad++; $display("FAIL short_recover got %0d beats want 1 of 654321fedcba", beats.size()); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL short_ferr_after got %b want 0", frame_err); end
  endtask

  task automatic test_startup();
    beats.delete();
    @(negedge clk);
    arst = 1'b1;
    i2s_lrclk = 1'b1;
    repeat (4) @(negedge clk);
    arst = 1'b0;
    send_bits(1'b1, 24'h777777, 10, 32, -1);
    repeat (4) @(negedge clk);
    n_cmp++; if (beats.size() != 0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL startup_quiet got %0d beats valid %b want 0", beats.size(), out_valid); end
    send_frame(24'h13579B, 24'h2468AC);
    n_cmp++; if (beats.size() != 1 || beats[0] !== 48'h13579B_2468AC) begin n_bad++; $display("FAIL startup_first got %0d beats want 1 of 13579b2468ac", beats.size()); end
  endtask

  task automatic test_arst_mid_word();
    beats.delete();
    set_ready(1'b0);
    send_frame(24'd7, 24'd8);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== {24'd7, 24'd8}) begin n_bad++; $display("FAIL arst_pre got valid %b data %h want 1 %h", out_valid, out_data, {24'd7, 24'd8}); end
    send_bits(1'b0, 24'h999999, 0, 10, -1);
    @(negedge clk);
    arst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 48'h0) begin n_bad++; $display("FAIL arst_data got %h want 0", out_data); end
    repeat (3) @(negedge clk);
    arst = 1'b0;
    set_ready(1'b1);
    send_bits(1'b0, 24'h999999, 10, 32, -1);
    send_bits(1'b1, 24'hABCDEF, 0, 32, -1);
    repeat (4) @(negedge clk);
    n_cmp++; if (beats.size() != 0) begin n_bad++; $display("FAIL arst_right_only got %0d beats want 0", beats.size()); end
    send_frame(24'h0C0FFE, 24'hBEEF01);
    n_cmp++; if (beats.size() != 1 || beats[0] !== 48'h0C0FFE_BEEF01) begin n_bad++; $display("FAIL arst_first got %0d beats want 1 of 0c0ffebeef01", beats.size()); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL arst_ferr got %b want 0", frame_err); end
  endtask

  task automatic test_ramp();
    logic [23:0] l;
    logic [23:0] r;
    beats.delete();
    for (int i = 0; i < 20; i++) begin
      l = 24'h100000 + 24'(i);
      r = 24'hF00000 - 24'(i * 3);
      send_frame(l, r);
    end
    n_cmp++; if (beats.size() != 20) begin n_bad++; $display("FAIL ramp_count got %0d want 20", beats.size()); end
    for (int i = 0; i < 20 && i < beats.size(); i++) begin
      l = 24'h100000 + 24'(i);
      r = 24'hF00000 - 24'(i * 3);
      n_cmp++; if (beats[i] !== {l, r}) begin n_bad++; $display("FAIL ramp_%0d got %h want %h", i, beats[i], {l, r}); end
    end
    n_cmp++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL ramp_errs got ovf %b ferr %b want 0 0", overflow, frame_err); end
  endtask

  initial begin
    arst      = 1'b1;
    i2s_sclk  = 1'b0;
    i2s_lrclk = 1'b1;
    i2s_sdata = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_short_slot();
    test_startup();
    test_arst_mid_word();
    test_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
